// File: rtl/mem_stream_packer.sv
// Packs read/write requests and a write-data stream into AXI-Stream frames:
// one header beat, then len+1 payload beats for writes. tlast marks frame end.
module mem_stream_packer #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [DATA_WIDTH-1:0]   wd_tdata,
  input  logic [DATA_WIDTH/8-1:0] wd_tstrb,
  input  logic                    wd_tvalid,
  output logic                    wd_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic                    req_err,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SUM_W  = ADDR_WIDTH + LEN_WIDTH + 1;
  localparam logic [SUM_W-1:0] LAST_WORD = SUM_W'(MEM_SIZE - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e                state_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [STRB_W-1:0]     tstrb_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  req_err_q;
  logic [15:0]           frame_cnt_q;

  logic [SUM_W-1:0]      end_addr_d;
  logic [DATA_WIDTH-1:0] hdr_d;
  logic                  out_done;
  logic                  out_free;
  logic                  req_fire;
  logic                  wd_fire;
  logic                  hdr_load;

  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic                  wr,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [LEN_WIDTH-1:0]  len
  );
    logic [DATA_WIDTH-1:0] h;
    h        = '0;
    h[31]    = wr;
    h[23:16] = 8'(len);
    h[15:0]  = 16'(addr);
    return h;
  endfunction

  // Extra carry bit keeps addr + len from wrapping before the bound compare.
  assign end_addr_d = SUM_W'(req_addr) + SUM_W'(req_len);
  assign hdr_d      = make_header(wr_q, addr_q, len_q);

  assign out_done  = tvalid_q && m01_axis_tready;
  assign out_free  = !tvalid_q || m01_axis_tready;
  assign req_ready = axis_aresetn && (state_q == IDLE) &&
                     (!tvalid_q || (m01_axis_tready && tlast_q));
  assign wd_tready = (state_q == DATA) && out_free;
  assign req_fire  = req_valid && req_ready;
  assign wd_fire   = wd_tvalid && wd_tready;
  assign hdr_load  = (state_q == HDR) && out_free;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      req_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      req_err_q <= 1'b0;
      if (out_done && tlast_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end

      // Output register: a new beat may load in the same cycle the old one drains.
      if (hdr_load) begin
        tdata_q  <= hdr_d;
        tstrb_q  <= '1;
        tlast_q  <= !wr_q;
        tvalid_q <= 1'b1;
      end else if (wd_fire) begin
        tdata_q  <= wd_tdata;
        tstrb_q  <= wd_tstrb;
        tlast_q  <= (cnt_q == '0);
        tvalid_q <= 1'b1;
      end else if (out_done) begin
        tvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (req_fire) begin
            wr_q   <= req_wr;
            addr_q <= req_addr;
            len_q  <= req_len;
            cnt_q  <= req_len;
            if (end_addr_d > LAST_WORD) begin
              req_err_q <= 1'b1;
            end else begin
              state_q <= HDR;
            end
          end
        end
        HDR: begin
          if (out_free) begin
            state_q <= wr_q ? DATA : IDLE;
          end
        end
        DATA: begin
          if (wd_fire) begin
            cnt_q <= cnt_q - LEN_WIDTH'(1);
            if (cnt_q == '0) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m01_axis_tdata  = tdata_q;
  assign m01_axis_tstrb  = tstrb_q;
  assign m01_axis_tvalid = tvalid_q;
  assign m01_axis_tlast  = tlast_q;
  assign req_err         = req_err_q;
  assign frame_cnt       = frame_cnt_q;
  assign busy            = (state_q != IDLE) || tvalid_q;

endmodule

// File: tb/tb_mem_stream_packer.sv
// Scoreboard bench for mem_stream_packer: requests and write data are queued,
// expected frames are modelled up front and compared against observed beats.
module tb_mem_stream_packer;

  logic        axis_aclk = 1'b0;
  logic        axis_aresetn;
  logic        req_valid, req_ready, req_wr;
  logic [11:0] req_addr;
  logic [7:0]  req_len;
  logic [31:0] wd_tdata;
  logic [3:0]  wd_tstrb;
  logic        wd_tvalid, wd_tready;
  logic [31:0] m01_axis_tdata;
  logic [3:0]  m01_axis_tstrb;
  logic        m01_axis_tvalid, m01_axis_tlast, m01_axis_tready;
  logic        req_err, busy;
  logic [15:0] frame_cnt;

  always #5 axis_aclk = ~axis_aclk;

  mem_stream_packer #(.MEM_SIZE(4096), .ADDR_WIDTH(12), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wd_tdata(wd_tdata), .wd_tstrb(wd_tstrb), .wd_tvalid(wd_tvalid), .wd_tready(wd_tready),
    .m01_axis_tdata(m01_axis_tdata), .m01_axis_tstrb(m01_axis_tstrb),
    .m01_axis_tvalid(m01_axis_tvalid), .m01_axis_tlast(m01_axis_tlast),
    .m01_axis_tready(m01_axis_tready),
    .req_err(req_err), .busy(busy), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  len;
  } req_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          err_pulses = 0;
  bit          wd_rdy_seen = 0;
  req_t        rq[$];
  logic [35:0] wq[$];
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  int          obs_t[$];
  int          acc_t[$];

  always @(posedge axis_aclk) cyc <= cyc + 1;

  always @(negedge axis_aclk) begin
    if (axis_aresetn && m01_axis_tvalid && m01_axis_tready) begin
      obs_q.push_back({m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata});
      obs_t.push_back(cyc);
    end
    if (req_err === 1'b1) err_pulses <= err_pulses + 1;
    if (wd_tready === 1'b1) wd_rdy_seen <= 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge axis_aclk);
    #1;
  endtask

  // Builds expected frames from the queued requests, then drives requests and
  // write data until everything is accepted and the block is idle.
  task automatic run(input bit do_stall, input logic [31:0] stall_word);
    int ri = 0;
    int wi = 0;
    int k = 0;
    int stall_n = 0;
    bit rhs, whs;
    bit fin = 0;
    foreach (rq[i]) begin
      if (int'(rq[i].addr) + int'(rq[i].len) <= 4095) begin
        exp_q.push_back({~rq[i].wr, 4'hF, rq[i].wr, 7'd0, rq[i].len, 4'd0, rq[i].addr});
        if (rq[i].wr) begin
          for (int j = 0; j <= int'(rq[i].len); j++) begin
            exp_q.push_back({(j == int'(rq[i].len)), wq[k]});
            k++;
          end
        end
      end
    end
    acc_t.delete();
    for (int c = 0; c < 2000 && !fin; c++) begin
      req_valid = (ri < rq.size());
      if (ri < rq.size()) {req_wr, req_addr, req_len} = rq[ri];
      wd_tvalid = (wi < wq.size());
      if (wi < wq.size()) {wd_tstrb, wd_tdata} = wq[wi];
      @(negedge axis_aclk);
      rhs = req_valid && req_ready;
      whs = wd_tvalid && wd_tready;
      if (rhs) acc_t.push_back(cyc);
      if (do_stall && !m01_axis_tready) begin
        total++;
        if ({m01_axis_tvalid, m01_axis_tdata, wd_tready} !== {1'b1, stall_word, 1'b0}) begin
          bad++;
          $display("FAIL bp_hold got tvalid=%0b tdata=%h wd_tready=%0b exp 1/%h/0",
                   m01_axis_tvalid, m01_axis_tdata, wd_tready, stall_word);
        end
      end
      @(posedge axis_aclk);
      #1;
      if (rhs) ri++;
      if (whs) wi++;
      if (do_stall && m01_axis_tvalid && m01_axis_tdata === stall_word && stall_n < 3) begin
        m01_axis_tready = 1'b0;
        stall_n++;
      end else begin
        m01_axis_tready = 1'b1;
      end
      fin = (ri == rq.size()) && (wi == wq.size()) && !busy;
    end
    req_valid = 1'b0;
    wd_tvalid = 1'b0;
    m01_axis_tready = 1'b1;
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout got req=%0d wd=%0d busy=%0b exp all consumed and idle", ri, wi, busy);
    end
    if (do_stall) begin
      total++;
      if (stall_n != 3) begin bad++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall_n); end
    end
    rq.delete();
    wq.delete();
  endtask

  task automatic test_reset();
    axis_aresetn = 1'b0;
    step(2);
    total++;
    if ({m01_axis_tvalid, m01_axis_tlast, m01_axis_tstrb, req_ready, wd_tready, req_err, busy} !== 10'b0) begin
      bad++;
      $display("FAIL rst_ctrl got=%b exp=0", {m01_axis_tvalid, m01_axis_tlast, m01_axis_tstrb, req_ready, wd_tready, req_err, busy});
    end
    total++;
    if ({m01_axis_tdata, frame_cnt} !== 48'h0) begin
      bad++; $display("FAIL rst_data got tdata=%h frame_cnt=%h exp 0/0", m01_axis_tdata, frame_cnt);
    end
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    step(1);
  endtask

  task automatic test_read();
    logic [36:0] e, o;
    wd_rdy_seen = 1'b0;
    obs_t.delete();
    rq.push_back('{wr: 1'b0, addr: 12'h010, len: 8'd0});
    run(1'b0, 32'h0);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL read_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL read_beat got=%h exp=%h", o, e); end
    end
    total++;
    if (obs_t.size() != 1 || acc_t.size() != 1 || obs_t[0] != acc_t[0] + 2) begin
      bad++; $display("FAIL read_latency got beat_cyc=%0d exp=%0d", obs_t.size() ? obs_t[0] : -1, acc_t.size() ? acc_t[0] + 2 : -1);
    end
    total++;
    if (frame_cnt !== 16'd1) begin bad++; $display("FAIL read_frame_cnt got=%0d exp=1", frame_cnt); end
    total++;
    if (wd_rdy_seen !== 1'b0) begin bad++; $display("FAIL read_wd_tready got=%b exp=0", wd_rdy_seen); end
  endtask

  task automatic test_write();
    logic [36:0] e, o;
    logic [15:0] fc0;
    fc0 = frame_cnt;
    obs_t.delete();
    rq.push_back('{wr: 1'b1, addr: 12'h100, len: 8'd3});
    wq.push_back({4'hF, 32'hA}); wq.push_back({4'hF, 32'hB});
    wq.push_back({4'hF, 32'hC}); wq.push_back({4'hF, 32'hD});
    run(1'b0, 32'h0);
    total++;
    if (obs_q.size() != 5 || exp_q.size() != 5) begin bad++; $display("FAIL write_count got=%0d exp=5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL write_beat got=%h exp=%h", o, e); end
    end
    total++;
    if (obs_t.size() != 5 || obs_t[4] - obs_t[0] != 4) begin
      bad++; $display("FAIL write_back_to_back got span=%0d exp=4", obs_t.size() == 5 ? obs_t[4] - obs_t[0] : -1);
    end
    total++;
    if (frame_cnt !== fc0 + 16'd1) begin bad++; $display("FAIL write_frame_cnt got=%0d exp=%0d", frame_cnt, fc0 + 16'd1); end
  endtask

  task automatic test_backpressure();
    logic [36:0] e, o;
    logic [15:0] fc0;
    fc0 = frame_cnt;
    obs_t.delete();
    rq.push_back('{wr: 1'b1, addr: 12'h100, len: 8'd3});
    wq.push_back({4'hF, 32'hA}); wq.push_back({4'hF, 32'hB});
    wq.push_back({4'hF, 32'hC}); wq.push_back({4'hF, 32'hD});
    run(1'b1, 32'hB);
    total++;
    if (obs_q.size() != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL bp_beat got=%h exp=%h", o, e); end
    end
    total++;
    if (obs_t.size() != 5 || obs_t[2] - obs_t[1] != 4) begin
      bad++; $display("FAIL bp_gap got=%0d exp=4", obs_t.size() == 5 ? obs_t[2] - obs_t[1] : -1);
    end
    total++;
    if (frame_cnt !== fc0 + 16'd1) begin bad++; $display("FAIL bp_frame_cnt got=%0d exp=%0d", frame_cnt, fc0 + 16'd1); end
  endtask

  task automatic test_range_error();
    logic [36:0] e, o;
    logic [15:0] fc0;
    fc0 = frame_cnt;
    err_pulses = 0;
    rq.push_back('{wr: 1'b1, addr: 12'hFFE, len: 8'd3});
    run(1'b0, 32'h0);
    step(3);
    total++;
    if (err_pulses != 1) begin bad++; $display("FAIL err_pulse_cycles got=%0d exp=1", err_pulses); end
    total++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin bad++; $display("FAIL err_no_frame got=%0d beats exp=0", obs_q.size()); end
    total++;
    if (frame_cnt !== fc0) begin bad++; $display("FAIL err_frame_cnt got=%0d exp=%0d", frame_cnt, fc0); end
    // A read right after the error, then a write ending exactly on the last word.
    rq.push_back('{wr: 1'b0, addr: 12'h7FF, len: 8'd0});
    rq.push_back('{wr: 1'b1, addr: 12'hFFC, len: 8'd3});
    wq.push_back({4'h1, 32'h1111_0001}); wq.push_back({4'h3, 32'h2222_0002});
    wq.push_back({4'h8, 32'h3333_0003}); wq.push_back({4'hF, 32'h4444_0004});
    run(1'b0, 32'h0);
    step(1);
    total++;
    if (obs_q.size() != 6) begin bad++; $display("FAIL edge_count got=%0d exp=6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL edge_beat got=%h exp=%h", o, e); end
    end
    total++;
    if (err_pulses != 1) begin bad++; $display("FAIL edge_no_err got=%0d exp=1", err_pulses); end
    total++;
    if (frame_cnt !== fc0 + 16'd2) begin bad++; $display("FAIL edge_frame_cnt got=%0d exp=%0d", frame_cnt, fc0 + 16'd2); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] e, o;
    logic [15:0] fc0;
    fc0 = frame_cnt;
    obs_t.delete();
    rq.push_back('{wr: 1'b0, addr: 12'h020, len: 8'd0});
    rq.push_back('{wr: 1'b1, addr: 12'h030, len: 8'd0});
    wq.push_back({4'hF, 32'h55});
    run(1'b0, 32'h0);
    total++;
    if (acc_t.size() != 2 || obs_t.size() != 3 || acc_t[1] != obs_t[0]) begin
      bad++; $display("FAIL b2b_accept got=%0d exp=%0d", acc_t.size() == 2 ? acc_t[1] : -1, obs_t.size() ? obs_t[0] : -1);
    end
    total++;
    if (acc_t.size() != 2 || obs_t.size() != 3 || obs_t[1] != acc_t[1] + 2) begin
      bad++; $display("FAIL b2b_hdr_latency got=%0d exp=%0d", obs_t.size() == 3 ? obs_t[1] : -1, acc_t.size() == 2 ? acc_t[1] + 2 : -1);
    end
    total++;
    if (obs_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b_beat got=%h exp=%h", o, e); end
    end
    total++;
    if (frame_cnt !== fc0 + 16'd2) begin bad++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt, fc0 + 16'd2); end
  endtask

  task automatic test_reset_mid_frame();
    logic [36:0] e, o;
    logic [31:0] words[4];
    int n = 0;
    bit rhs, whs;
    words = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 12'h200; req_len = 8'd3;
    wd_tvalid = 1'b1; wd_tstrb = 4'hF; wd_tdata = words[0];
    for (int c = 0; c < 100 && n < 2; c++) begin
      @(negedge axis_aclk);
      rhs = req_valid && req_ready;
      whs = wd_tvalid && wd_tready;
      @(posedge axis_aclk);
      #1;
      if (rhs) req_valid = 1'b0;
      if (whs) n++;
      wd_tdata = words[n];
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL mid_setup got=%0d beats exp=2", n); end
    #2;
    axis_aresetn = 1'b0;
    wd_tvalid = 1'b0;
    #1;
    total++;
    if ({m01_axis_tvalid, m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata} !== 38'h0) begin
      bad++; $display("FAIL mid_rst_out got=%h exp=0", {m01_axis_tvalid, m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata});
    end
    total++;
    if ({req_ready, wd_tready, busy, frame_cnt} !== 19'h0) begin
      bad++; $display("FAIL mid_rst_ctrl got ready=%b wd=%b busy=%b cnt=%0d exp 0", req_ready, wd_tready, busy, frame_cnt);
    end
    step(2);
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    #1;
    total++;
    if ({busy, frame_cnt, req_ready} !== 18'h1) begin
      bad++; $display("FAIL mid_release got busy=%b cnt=%0d ready=%b exp 0/0/1", busy, frame_cnt, req_ready);
    end
    step(1);
    exp_q.delete(); obs_q.delete(); obs_t.delete();
    rq.push_back('{wr: 1'b0, addr: 12'h3A5, len: 8'd0});
    run(1'b0, 32'h0);
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL mid_read_count got=%0d exp=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL mid_read_beat got=%h exp=%h", o, e); end
    end
    total++;
    if (frame_cnt !== 16'd1) begin bad++; $display("FAIL mid_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  initial begin
    axis_aresetn = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wd_tdata = '0; wd_tstrb = '0; wd_tvalid = 1'b0;
    m01_axis_tready = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_range_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stream_packer.md
Name: mem_stream_packer

Overview:
- Upstream feeder for the memory wrapper's slave AXI-Stream port (s01_axis_*).
- Converts simple request commands (read/write, address, beat count) plus a separate write-data stream into framed AXI-Stream packets for the memory controller.
- Each frame is one header beat, followed by zero (read) or N (write) data beats. tlast is asserted on the final beat of every frame.

Parameters:
- MEM_SIZE, 4096, memory depth in words; used for the range check.
- ADDR_WIDTH, 12, word address width; must be <= 16.
- DATA_WIDTH, 32, stream data width; fixed at 32 because the header layout depends on it.
- LEN_WIDTH, 8, width of the beats-minus-one field; must be <= 8.

Ports:
- axis_aclk  in  1  block clock
- axis_aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  start word address
- req_len  in  LEN_WIDTH  number of data beats minus one (1..256 words)
- wd_tdata  in  DATA_WIDTH  write-data payload
- wd_tstrb  in  DATA_WIDTH/8  write-data byte strobes
- wd_tvalid  in  1  write-data valid
- wd_tready  out  1  write-data ready
- m01_axis_tdata  out  DATA_WIDTH  frame beat
- m01_axis_tstrb  out  DATA_WIDTH/8  beat strobes
- m01_axis_tvalid  out  1  beat valid
- m01_axis_tlast  out  1  final beat of frame
- m01_axis_tready  in  1  downstream ready
- req_err  out  1  one-cycle pulse: request rejected
- busy  out  1  frame in progress or output beat pending
- frame_cnt  out  16  frames fully sent; wraps at 0xFFFF -> 0

Behaviour:
- Clock and reset: single clock, axis_aclk. Reset axis_aresetn is asynchronous, active-low. All state is cleared on reset assertion.
- Reset values:
  - state = IDLE
  - m01_axis_tvalid = 0, m01_axis_tlast = 0, m01_axis_tdata = 0, m01_axis_tstrb = 0
  - req_ready = 0 during reset; 1 in the first cycle after reset release
  - wd_tready = 0, req_err = 0, busy = 0, frame_cnt = 0
- Header layout:
  - [31] = wr
  - [30:24] = 0
  - [23:16] = req_len, zero-extended
  - [15:ADDR_WIDTH] = 0
  - [ADDR_WIDTH-1:0] = addr
  - Header tstrb is all ones.
- Output register: m01 outputs are registered. Once tvalid = 1, tdata/tstrb/tlast are held stable until tvalid && tready. A new beat may load in the same cycle a beat completes, giving full throughput of 1 beat/cycle.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - req_ready = !m01_axis_tvalid || (m01_axis_tready && m01_axis_tlast).
  - On acceptance, latch wr/addr/len.
  - Range check: addr + len must be <= MEM_SIZE-1, computed at ADDR_WIDTH+LEN_WIDTH+1 bits so it cannot overflow.
  - If the check fails: req_err pulses in the next cycle, no frame is emitted, state stays IDLE.
  - If the check passes: state -> HDR.
- HDR: load the header beat into the output register. tlast = !wr. Then go to DATA if wr, else IDLE.
- DATA:
  - wd_tready = !m01_axis_tvalid || m01_axis_tready.
  - Each wd handshake loads one beat, with tstrb = wd_tstrb, and decrements the remaining-beat counter (initialised to len).
  - The beat loaded with counter == 0 carries tlast = 1, and the state returns to IDLE.
  - wd_tready = 0 in every state other than DATA.
- Latency: request accepted at cycle T -> header tvalid at T+2 (if downstream is ready).
- frame_cnt increments on the handshake of each tlast beat.
- busy = (state != IDLE) || m01_axis_tvalid.
- Write-data stall: a wd_tvalid gap inside a frame leaves m01_axis_tvalid low after the pending beat drains. The frame is never terminated early.
- Reset mid-frame: the frame is abandoned immediately and no tlast is emitted. Downstream is expected to share the same reset.
- Same-cycle events: a req_valid arriving in the cycle the final tlast beat completes is accepted in that cycle (back-to-back frames, no bubble beyond the HDR cycle).

Test Plan:
- Read request: addr = 0x010, len = 0 -> one beat, tdata = 0x0000_0010, tlast = 1, frame_cnt = 1, wd_tready never asserted.
- Write request: addr = 0x100, len = 3, data 0xA, 0xB, 0xC, 0xD with tstrb = 0xF -> beats 0x8003_0100, 0xA, 0xB, 0xC, 0xD; tlast only on 0xD; 5 consecutive cycles with tready = 1.
- Backpressure: same write with tready low for 3 cycles while beat 0xB is presented -> 0xB held stable, no beat lost or duplicated, wd_tready low during the stall.
- Range error: addr = 0xFFE, len = 3 -> req_err pulses for exactly 1 cycle, no tvalid, frame_cnt unchanged; a following valid read still succeeds.
- Back-to-back requests: read 0x020 then write 0x030 len = 0 (data 0x55) with tready = 1 -> frames 0x0000_0020 (tlast); then 0x8000_0030, 0x55 (tlast); frame_cnt = 2.
- Reset mid-write after 2 of 4 data beats -> outputs reset values immediately; after release, busy = 0, frame_cnt = 0, and a new read emits a correct header.
